// File: rtl/add_result_accum.sv
// Batch accumulator for a 3-bit adder result {c2,s1,s0}. It sums NSAMP samples,
// then holds the total until the consumer takes it.
module add_result_accum #(
    parameter int unsigned NSAMP = 4,
    parameter int unsigned ACCW  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s0,
    input  logic            s1,
    input  logic            c2,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            clear,
    output logic [ACCW-1:0] acc_out,
    output logic [3:0]      cnt,
    output logic            ovf,
    output logic            out_valid,
    input  logic            out_ready
);

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    localparam logic [3:0] nsamp_c = 4'(NSAMP);

    state_t        state;
    logic [2:0]    v;
    logic [ACCW:0] sum;
    logic [3:0]    cnt_nxt;

    assign v       = {c2, s1, s0};
    // One extra bit keeps the carry out of the accumulator for the overflow flag.
    assign sum     = {1'b0, acc_out} + (ACCW + 1)'(v);
    assign cnt_nxt = cnt + 4'd1;

    // in_ready and out_valid are registered copies of the state decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc_out   <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else if (clear) begin
            state     <= IDLE;
            acc_out   <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc_out <= ACCW'(v);
                        cnt     <= 4'd1;
                        ovf     <= 1'b0;
                        if (nsamp_c == 4'd1) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        acc_out <= sum[ACCW-1:0];
                        cnt     <= cnt_nxt;
                        ovf     <= ovf | sum[ACCW];
                        if (cnt_nxt == nsamp_c) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
